conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_addr_gen.sv | 24 ++
 rtl/conv_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing for the convolution sequencer.
// Address widths are sized for an 8x8 image and a kernel of up to 3x3.
package conv_pkg;
    localparam int IMG_MAX = 8;
    localparam int K_MAX   = 3;
    localparam int IMG_AW  = 6;
    localparam int K_AW    = 4;
    localparam int CRD_W   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_K,
        S_LOAD_I,
        S_MAC,
        S_EMIT,
        S_DONE
    } conv_state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// Window address generator: maps output pixel (r,c) and kernel term (i,j)
// to the image and kernel memory addresses.
module conv_addr_gen
    import conv_pkg::*;
(
    input  logic [CRD_W-1:0]  r,
    input  logic [CRD_W-1:0]  c,
    input  logic [1:0]        i,
    input  logic [1:0]        j,
    input  logic [3:0]        n,
    input  logic [1:0]        k,
    output logic [IMG_AW-1:0] img_addr,
    output logic [K_AW-1:0]   k_addr
);
    logic [7:0] row, col;

    // Computed 8 bits wide so the intermediate product never wraps before truncation.
    always_comb begin
        row      = 8'(r) + 8'(i);
        col      = 8'(c) + 8'(j);
        img_addr = IMG_AW'(row * 8'(n) + col);
        k_addr   = K_AW'(i) * K_AW'(k) + K_AW'(j);
    end
endmodule

// File: rtl/conv_sequencer.sv
// Convolution job sequencer: loads kernel then image, then walks every valid
// window issuing K*K MAC terms per output pixel and handing out coordinates.
module conv_sequencer #(
    parameter int IMG_MAX = conv_pkg::IMG_MAX,
    parameter int K_MAX   = conv_pkg::K_MAX
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         start,
    input  logic [3:0]                   cfg_img_size,
    input  logic [1:0]                   cfg_k_size,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         wr_en,
    output logic                         wr_sel,
    output logic [conv_pkg::IMG_AW-1:0]  wr_addr,
    output logic                         mac_en,
    output logic                         mac_clr,
    output logic [conv_pkg::IMG_AW-1:0]  rd_img_addr,
    output logic [conv_pkg::K_AW-1:0]    rd_k_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [conv_pkg::CRD_W-1:0]   out_row,
    output logic [conv_pkg::CRD_W-1:0]   out_col,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);
    import conv_pkg::*;

    conv_state_e      state;
    logic [3:0]       n_q;
    logic [1:0]       k_q;
    logic [5:0]       cnt;
    logic [CRD_W-1:0] r, c, lim;
    logic [1:0]       i, j;
    logic             err_q;
    logic [6:0]       last;
    logic             cfg_ok;
    logic [IMG_AW-1:0] img_a;
    logic [K_AW-1:0]   k_a;

    assign last   = ((state == S_LOAD_K) ? 7'(k_q) * 7'(k_q) : 7'(n_q) * 7'(n_q)) - 7'd1;
    assign lim    = CRD_W'(n_q - 4'(k_q));
    assign cfg_ok = (cfg_k_size >= 2'd2) && (int'(cfg_k_size) <= K_MAX) &&
                    (4'(cfg_k_size) <= cfg_img_size) && (int'(cfg_img_size) <= IMG_MAX);

    conv_addr_gen u_addr_gen (
        .r        (r),
        .c        (c),
        .i        (i),
        .j        (j),
        .n        (n_q),
        .k        (k_q),
        .img_addr (img_a),
        .k_addr   (k_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            n_q   <= '0;
            k_q   <= '0;
            cnt   <= '0;
            r     <= '0;
            c     <= '0;
            i     <= '0;
            j     <= '0;
            err_q <= 1'b0;
        end else if (ena) begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    if (cfg_ok) begin
                        n_q   <= cfg_img_size;
                        k_q   <= cfg_k_size;
                        cnt   <= '0;
                        state <= S_LOAD_K;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                S_LOAD_K, S_LOAD_I: if (in_valid) begin
                    if ({1'b0, cnt} == last) begin
                        cnt <= '0;
                        if (state == S_LOAD_K) begin
                            state <= S_LOAD_I;
                        end else begin
                            r     <= '0;
                            c     <= '0;
                            i     <= '0;
                            j     <= '0;
                            state <= S_MAC;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_MAC: begin
                    // j runs fastest; the last term hands over to EMIT.
                    if (j == k_q - 2'd1) begin
                        j <= '0;
                        if (i == k_q - 2'd1) begin
                            i     <= '0;
                            state <= S_EMIT;
                        end else begin
                            i <= i + 2'd1;
                        end
                    end else begin
                        j <= j + 2'd1;
                    end
                end
                S_EMIT: if (out_ready) begin
                    if (r == lim && c == lim) begin
                        state <= S_DONE;
                    end else begin
                        if (c == lim) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                        state <= S_MAC;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from registered state; strobes and handshakes drop while ena is low.
    always_comb begin
        in_ready    = ena && (state == S_LOAD_K || state == S_LOAD_I);
        wr_en       = in_ready && in_valid;
        wr_sel      = wr_en && (state == S_LOAD_K);
        wr_addr     = wr_en ? cnt : '0;
        mac_en      = ena && (state == S_MAC);
        mac_clr     = mac_en && (i == 2'd0) && (j == 2'd0);
        rd_img_addr = (state == S_MAC) ? img_a : '0;
        rd_k_addr   = (state == S_MAC) ? k_a : '0;
        out_valid   = ena && (state == S_EMIT);
        out_row     = (state == S_EMIT) ? r : '0;
        out_col     = (state == S_EMIT) ? c : '0;
        busy        = (state != S_IDLE);
        done        = ena && (state == S_DONE);
        err         = ena && err_q;
    end
endmodule
